byte_transmitter_mux: RTL and testbench
=======================================

Name: byte_transmitter_mux

Overview:
- Parallel-in, serial-out transmitter that shifts a WIDTH-bit word out one bit per clock, least significant bit first.
- Pairs with a 2:1 output selector that drives the TAP data-out pin from either the transmitter or a controller-supplied bit.
- Sits inside the JTAG TAP, clocked by tck. Used to shift the IDCODE DR value onto TDO during Shift-DR.

Parameters:
- WIDTH, 32, number of bits in the parallel word; must be ≥ 2.

Ports:
- clk  input  1  TAP clock (tck); all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of transmit progress; same effect as reset, applied at the clock edge.
- enable  input  1  advance the transmitter by one bit per cycle while high.
- in  input  WIDTH  parallel word to transmit.
- tap_bit  input  1  bit supplied by the TAP controller.
- select_tap  input  1  output select: 1 = tap_bit, 0 = transmitter bit.
- tx_out  output  1  registered serial bit from the transmitter.
- done  output  1  high once all WIDTH bits have been presented.
- tdo  output  1  selected output bit.

Behaviour:
- Reset (reset_n low, asynchronous): bit counter = 0, shift register = 0, tx_out = 0, done = 0. The clear input produces the same values synchronously and has priority over enable.
- Counter width is $clog2(WIDTH+1); its range is 0..WIDTH.
- Enable high, counter = 0: capture in. tx_out <= in[0], shift register <= in >> 1, counter <= 1.
- Enable high, 0 < counter < WIDTH: tx_out <= sreg[0], sreg <= sreg >> 1, counter increments.
- Enable high, counter = WIDTH: done <= 1, tx_out <= 0, counter holds.
- Latency: bit k appears on tx_out after the (k+1)th enabled edge. done rises on the enabled edge following the edge that presented bit WIDTH-1.
- Enable low: all state holds, including tx_out; bits are paused, not lost.
- Once done is 1 it stays 1, with tx_out = 0, until clear or reset. A new transfer needs clear first. Enable while done = 1 has no effect.
- in is sampled only at the counter = 0 capture edge. Later changes to in do not affect the word in flight.
- Clear or reset mid-transfer abandons the word. The next enable recaptures in from bit 0.
- Mux is purely combinational: tdo = select_tap ? tap_bit : tx_out. There is no latency, and tdo is never X when its inputs are known.
- After reset with select_tap = 1 and tap_bit = 0: tdo = 0.

Optional Feature:
- Macro BYTE_TX_MSB_FIRST_EN.
- Defined: transmission order is MSB first. The capture edge presents in[WIDTH-1], the shift register shifts left, and each subsequent bit is taken from sreg[WIDTH-1]. Counter and done timing are unchanged.
- Undefined (default): LSB first, as described in Behaviour.

Decomposition:
- Shared package jtag_pkg holds the IDCODE constant (32'h000FAF01), the default WIDTH, the TAP state encodings (TestLogicReset = 0 through UpdateIr = 15), and the IR opcodes (Abort = 4'b1000, IdCode = 4'b1110, Bypass = 4'b1111).
- One natural sub-module: mux_2_1, with ports one, two, selector, out, where out = selector ? one : two.

Test Plan:
- Reset: reset_n low mid-cycle with no clock edge → tx_out = 0, done = 0 immediately; with select_tap = 1 and tap_bit = 0, tdo = 0.
- IDCODE shift, LSB first: in = 32'h000FAF01, enable held high for 33 cycles.
  - tx_out sequence: 1,0,0,0,0,0,0,0, 1,1,1,1, 0,1,0,1, 1,1,1,1, then twelve 0s.
  - done rises on the 33rd edge.
- Pause: deassert enable for 3 cycles after bit 5 → tx_out holds bit 5; resuming yields bit 6 with no skipped or repeated bits.
- Done hold and restart: after done, keep enable high and change in → done stays 1, tx_out stays 0. Pulse clear → done = 0, and the next enable presents the new in[0].
- Mid-transfer clear: clear after bit 10, with in changed to 32'hFFFFFFFF → the next 32 enabled edges output all 1s, then done rises.
- Mux: toggle select_tap with tap_bit = 1 and tx_out = 0 → tdo follows the selected input in the same cycle. Under BYTE_TX_MSB_FIRST_EN with in = 32'h80000001, the first bit is 1, followed by thirty 0s, then 1.

Source files
------------

// File: rtl/jtag_pkg.sv
// jtag_pkg: constants shared across the JTAG TAP blocks.
//   IDCODE_VALUE  - device identification word shifted out in Shift-DR
//   DEFAULT_WIDTH - default DR width for the IDCODE transmitter
//   tap_state_e   - TAP controller state encodings (TestLogicReset = 0 .. UpdateIr = 15)
//   ir_opcode_e   - instruction register opcodes
package jtag_pkg;

   localparam logic [31:0] IDCODE_VALUE  = 32'h000FAF01;
   localparam int          DEFAULT_WIDTH = 32;

   typedef enum logic [3:0] {
      TestLogicReset = 4'd0,
      RunTestIdle    = 4'd1,
      SelectDrScan   = 4'd2,
      CaptureDr      = 4'd3,
      ShiftDr        = 4'd4,
      Exit1Dr        = 4'd5,
      PauseDr        = 4'd6,
      Exit2Dr        = 4'd7,
      UpdateDr       = 4'd8,
      SelectIrScan   = 4'd9,
      CaptureIr      = 4'd10,
      ShiftIr        = 4'd11,
      Exit1Ir        = 4'd12,
      PauseIr        = 4'd13,
      Exit2Ir        = 4'd14,
      UpdateIr       = 4'd15
   } tap_state_e;

   typedef enum logic [3:0] {
      Abort  = 4'b1000,
      IdCode = 4'b1110,
      Bypass = 4'b1111
   } ir_opcode_e;

endpackage

// File: rtl/mux_2_1.sv
// mux_2_1: combinational 2:1 bit selector.
//   one      - selected when selector = 1
//   two      - selected when selector = 0
//   selector - select input
//   out      - selector ? one : two
module mux_2_1 (
   input  logic one,
   input  logic two,
   input  logic selector,
   output logic out
);

   assign out = selector ? one : two;

endmodule

// File: rtl/byte_transmitter_mux.sv
// byte_transmitter_mux: parallel-in / serial-out transmitter feeding a 2:1
// TDO selector. Captures a WIDTH-bit word on the first enabled edge and
// presents one bit per enabled edge on a registered tx_out; done rises on
// the enabled edge after the last bit and sticks until clear or reset.
//
// Build option: define BYTE_TX_MSB_FIRST_EN to transmit MSB first
// (default is LSB first). Counter and done timing are identical.
//
// Ports:
//   clk        - TAP clock (tck), rising edge
//   reset_n    - asynchronous active-low reset
//   clear      - synchronous clear of transmit progress (beats enable)
//   enable     - advance one bit per cycle while high
//   in         - parallel word, sampled only at the capture edge
//   tap_bit    - bit supplied by the TAP controller
//   select_tap - 1 = tdo from tap_bit, 0 = tdo from tx_out
//   tx_out     - registered serial bit
//   done       - all WIDTH bits presented
//   tdo        - selected output bit (combinational)
module byte_transmitter_mux
   import jtag_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] in,
   input  logic             tap_bit,
   input  logic             select_tap,
   output logic             tx_out,
   output logic             done,
   output logic             tdo
);

   localparam int            CW      = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

   if (WIDTH < 2) begin : g_width_chk
      $error("byte_transmitter_mux: WIDTH must be >= 2");
   end

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sreg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         sreg   <= '0;
         tx_out <= 1'b0;
         done   <= 1'b0;
      end else if (clear) begin
         cnt    <= '0;
         sreg   <= '0;
         tx_out <= 1'b0;
         done   <= 1'b0;
      end else if (enable) begin
         if (cnt == '0) begin
            // capture edge: first bit goes straight out, remainder parked in sreg
`ifdef BYTE_TX_MSB_FIRST_EN
            tx_out <= in[WIDTH-1];
            sreg   <= in << 1;
`else
            tx_out <= in[0];
            sreg   <= in >> 1;
`endif
            cnt    <= CW'(1);
         end else if (cnt < CNT_MAX) begin
`ifdef BYTE_TX_MSB_FIRST_EN
            tx_out <= sreg[WIDTH-1];
            sreg   <= sreg << 1;
`else
            tx_out <= sreg[0];
            sreg   <= sreg >> 1;
`endif
            cnt    <= cnt + CW'(1);
         end else begin
            // counter parks at WIDTH; done is sticky until clear/reset
            done   <= 1'b1;
            tx_out <= 1'b0;
         end
      end
   end

   mux_2_1 u_tdo_mux (
      .one      (tap_bit),
      .two      (tx_out),
      .selector (select_tap),
      .out      (tdo)
   );

endmodule

// File: tb/tb_byte_transmitter_mux.sv
// Bench for byte_transmitter_mux: directed stimulus, a per-cycle compare
// against an edge-count model, and literal checks pinning the model.
module tb_byte_transmitter_mux;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset_n, clear, enable, tap_bit, select_tap;
   logic [W-1:0] in_w;
   logic         tx_out, done, tdo;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   byte_transmitter_mux #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (clear),
      .enable     (enable),
      .in         (in_w),
      .tap_bit    (tap_bit),
      .select_tap (select_tap),
      .tx_out     (tx_out),
      .done       (done),
      .tdo        (tdo)
   );

   // Model: count enabled edges since the last clear/reset (saturating at
   // W+1). Edge n (1..W) presents transmit-order bit n-1; beyond W, done.
   int unsigned  m_k;
   logic [W-1:0] m_word;

   function automatic logic pick(input logic [W-1:0] w, input int unsigned i);
`ifdef BYTE_TX_MSB_FIRST_EN
      return w[W-1-i];
`else
      return w[i];
`endif
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m_k <= 0;
      else if (clear) m_k <= 0;
      else if (enable && m_k <= W) begin
         if (m_k == 0) m_word <= in_w;
         m_k <= m_k + 1;
      end
   end

   function automatic logic exp_tx();
      return (m_k >= 1 && m_k <= W) ? pick(m_word, m_k - 1) : 1'b0;
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_tx", tx_out, exp_tx());
         chk("model_done", done, (m_k > W));
         chk("model_tdo", tdo, select_tap ? tap_bit : exp_tx());
      end
   end

   // advance to 2 time units after the next rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // hand-derived IDCODE 32'h000FAF01 bit sequence, LSB first, in send order
   logic [31:0] idcode_seq = 32'b10000000_11110101_11110000_00000000;

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; clear = 1'b0; enable = 1'b0; in_w = '0;
      tap_bit = 1'b0; select_tap = 1'b1;
      #3;
      chk("reset_tx", tx_out, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_tdo", tdo, 1'b0);
      tick(); tick();
      reset_n = 1'b1; select_tap = 1'b0;
      chk_en = 1'b1;
      tick();

      // IDCODE shift with a 3-cycle pause after bit 5
      in_w = jtag_pkg::IDCODE_VALUE;
      enable = 1'b1;
      for (int k = 0; k < W; k++) begin
         tick();
`ifndef BYTE_TX_MSB_FIRST_EN
         chk("idcode_bit", tx_out, idcode_seq[31-k]);
`endif
         chk("idcode_not_done", done, 1'b0);
         if (k == 5) begin
            enable = 1'b0;
            in_w = 32'h5555_5555;  // must not disturb the word in flight
            for (int p = 0; p < 3; p++) begin
               tick();
`ifndef BYTE_TX_MSB_FIRST_EN
               chk("pause_hold", tx_out, 1'b0);
`endif
            end
            enable = 1'b1;
         end
      end
      tick();
      chk("idcode_done", done, 1'b1);
      chk("idcode_done_tx", tx_out, 1'b0);

      // done is sticky under enable and changing input
      in_w = 32'h1234_5679;
      for (int p = 0; p < 3; p++) begin
         tick();
         chk("hold_done", done, 1'b1);
         chk("hold_tx", tx_out, 1'b0);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clear_done", done, 1'b0);
      chk("clear_tx", tx_out, 1'b0);
      tick();
`ifdef BYTE_TX_MSB_FIRST_EN
      chk("restart_bit0", tx_out, 1'b0);
`else
      chk("restart_bit0", tx_out, 1'b1);
`endif

      // mid-transfer clear after bit 10, then an all-ones word
      for (int k = 1; k <= 10; k++) tick();
      clear = 1'b1; in_w = 32'hFFFF_FFFF;
      tick();
      clear = 1'b0;
      for (int k = 0; k < W; k++) begin
         tick();
         chk("ones_bit", tx_out, 1'b1);
         chk("ones_not_done", done, 1'b0);
      end
      tick();
      chk("ones_done", done, 1'b1);

      // mux follows select_tap within the cycle (tx_out is 0 here)
      tap_bit = 1'b1; select_tap = 1'b1;
      #1 chk("mux_tap", tdo, 1'b1);
      select_tap = 1'b0;
      #1 chk("mux_tx", tdo, 1'b0);

      // 32'h80000001: 1, thirty 0s, 1 in either bit order
      clear = 1'b1; in_w = 32'h8000_0001;
      tick();
      clear = 1'b0;
      for (int k = 0; k < W; k++) begin
         tick();
         chk("edge_word", tx_out, (k == 0 || k == W-1));
      end

      // asynchronous reset mid-cycle, mid-transfer
      clear = 1'b1; in_w = 32'hFFFF_FFFF;
      tick();
      clear = 1'b0;
      tick(); tick();
      chk("pre_reset_tx", tx_out, 1'b1);
      select_tap = 1'b1; tap_bit = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("async_tx", tx_out, 1'b0);
      chk("async_done", done, 1'b0);
      chk("async_tdo", tdo, 1'b0);
      tick();
      reset_n = 1'b1; select_tap = 1'b0;
      tick();
      chk("post_reset_bit0", tx_out, 1'b1);
      tick(); tick();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
